// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle iterative restoring divider for DIV / DIVU.
//
// Retires one quotient bit per clock. Results have a fixed latency of WIDTH
// cycles after the accepting start edge, whatever the operand values. The
// quotient is the LO result and the remainder is the HI result. Both feed the
// writeback ALU/divider select. The control unit stalls the pipe while busy=1.
//
// Ports:
//   clk        in   system clock, rising-edge
//   rst        in   synchronous active-high reset (aborts a running division)
//   start      in   division request, sampled only while busy=0
//   is_signed  in   1 = DIV (two's complement), 0 = DIVU; captured with start
//   dividend   in   WIDTH-bit numerator, captured with start
//   divisor    in   WIDTH-bit denominator, captured with start
//   busy       out  high while a division is in progress
//   done       out  one-cycle pulse when quotient/remainder are updated
//   quotient   out  LO result, held until the next completion
//   remainder  out  HI result, held until the next completion
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  // FINISH is the done cycle. It behaves like IDLE, so a start is accepted there.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;        // remaining steps
  logic [WIDTH-1:0] rem_q,       rem_d;        // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q,       quo_d;        // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvsr_q,      dvsr_d;       // divisor magnitude
  logic             neg_quo_q,   neg_quo_d;
  logic             neg_rem_q,   neg_rem_d;
  logic             dz_q,        dz_d;         // divide-by-zero flag
  logic [WIDTH-1:0] raw_dvnd_q,  raw_dvnd_d;   // dividend as captured, for x/0
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  // Operand magnitudes. Negating 0x80..0 gives 0x80..0 back. Read as unsigned,
  // that is the correct magnitude, so the most negative value needs no special case.
  logic             dvnd_neg, dvsr_neg;
  logic [WIDTH-1:0] dvnd_mag, dvsr_mag;

  always_comb begin
    dvnd_neg = is_signed & dividend[WIDTH-1];
    dvsr_neg = is_signed & divisor[WIDTH-1];
    dvnd_mag = dvnd_neg ? (~dividend + 1'b1) : dividend;
    dvsr_mag = dvsr_neg ? (~divisor + 1'b1) : divisor;
  end

  // One restoring step. The partial remainder is always below the divisor, so the
  // shifted value fits in WIDTH+1 bits. Bit WIDTH of the trial difference is then
  // a reliable borrow.
  logic [WIDTH:0]   shifted, trial;
  logic             step_ok;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    step_ok  = ~trial[WIDTH];
    step_rem = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], step_ok};

    // Sign correction is applied to the result of the final step. On divide by
    // zero, the fixed answer overrides any sign rule.
    quo_fin  = dz_q ? {WIDTH{1'b1}}
                    : (neg_quo_q ? (~step_quo + 1'b1) : step_quo);
    rem_fin  = dz_q ? raw_dvnd_q
                    : (neg_rem_q ? (~step_rem + 1'b1) : step_rem);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    raw_dvnd_d  = raw_dvnd_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (start) begin
          state_d    = S_RUN;
          cnt_d      = CW'(WIDTH);
          rem_d      = '0;
          quo_d      = dvnd_mag;
          dvsr_d     = dvsr_mag;
          neg_quo_d  = dvnd_neg ^ dvsr_neg;
          neg_rem_d  = dvnd_neg;
          dz_d       = (divisor == '0);
          raw_dvnd_d = dividend;
        end
      end

      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        // The last step and the result write share the same edge.
        if (cnt_q == CW'(1)) begin
          state_d     = S_FINISH;
          quotient_d  = quo_fin;
          remainder_d = rem_fin;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      raw_dvnd_q  <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      raw_dvnd_q  <= raw_dvnd_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_FINISH);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
